bram_fifo_tx: RTL

Single-clock, parametrised first-word-fall-through FIFO built on inferred simple-dual-port block RAM. It is the buffering stage on the DDR3-to-UART transmit path. It replaces bare addressed RAM access with a valid/ready handshake on both sides, occupancy tracking, programmable almost-full/almost-empty flags and a synchronous flush. It sustains one word per cycle in and out, and absorbs the one-cycle RAM read latency internally.

---
 rtl/bram_fifo_pkg.sv | 20 ++
 rtl/bram_fifo_tx_bram_sdp.sv | 31 +++
 rtl/bram_fifo_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared sizing helpers and default thresholds for the BRAM-backed tx/rx FIFOs.
package bram_fifo_pkg;

  localparam int DEF_WIDTH_DATA   = 256;
  localparam int DEF_WIDTH_ADDR   = 10;
  localparam int DEF_AEMPTY_LVL   = 4;
  localparam int DEF_AFULL_MARGIN = 4;

  // One extra pointer bit distinguishes full from empty after a wrap
  localparam int PTR_WRAP_BITS = 1;

  function automatic int depth_of(input int width_addr);
    return 1 << width_addr;
  endfunction

  function automatic int ptr_w(input int width_addr);
    return width_addr + PTR_WRAP_BITS;
  endfunction

endpackage

// File: rtl/bram_fifo_tx_bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
module bram_sdp
  import bram_fifo_pkg::*;
#(
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int WIDTH_ADDR = DEF_WIDTH_ADDR
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [WIDTH_ADDR-1:0] i_waddr,
  input  logic [WIDTH_DATA-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [WIDTH_ADDR-1:0] i_raddr,
  output logic [WIDTH_DATA-1:0] o_rdata
);

  localparam int DEPTH = depth_of(WIDTH_ADDR);

  logic [WIDTH_DATA-1:0] mem [0:DEPTH-1];

  // Array and read register carry no reset so the tools map them onto block RAM
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= mem[i_raddr];
    end
  end

endmodule

// File: rtl/bram_fifo_tx.sv
// First-word-fall-through FIFO over block RAM with a 2-entry output buffer
// that hides the RAM read latency and sustains one word per cycle.
module bram_fifo_tx
  import bram_fifo_pkg::*;
#(
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int WIDTH_ADDR = DEF_WIDTH_ADDR,
  parameter int AFULL_LVL  = depth_of(WIDTH_ADDR) - DEF_AFULL_MARGIN,
  parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [WIDTH_DATA-1:0] i_WDATA,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [WIDTH_DATA-1:0] o_RDATA,
  output logic [WIDTH_ADDR:0]   o_count,
  output logic                  o_almost_full,
  output logic                  o_almost_empty
);

  localparam int DEPTH = depth_of(WIDTH_ADDR);
  localparam int PTR_W = ptr_w(WIDTH_ADDR);
  localparam int CNT_W = WIDTH_ADDR + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  push;
  logic                  pop;
  logic                  ram_empty;
  logic                  issue;
  logic [2:0]            occ_after_pop;

  logic                  vld_p0;
  logic [WIDTH_DATA-1:0] ram_rdata_p0;

  logic                  head_vld_p1;
  logic                  spare_vld_p1;
  logic [WIDTH_DATA-1:0] head_data_p1;
  logic [WIDTH_DATA-1:0] spare_data_p1;

  always_comb begin
    push          = i_wr_valid & o_wr_ready;
    pop           = head_vld_p1 & i_rd_ready;
    ram_empty     = (rptr == wptr);
    occ_after_pop = {2'b0, head_vld_p1} + {2'b0, spare_vld_p1} + {2'b0, vld_p0}
                  - {2'b0, pop};
    issue         = !ram_empty && (occ_after_pop < 3'd2);
    cnt_nxt       = o_count;
    case ({push, pop})
      2'b10:   cnt_nxt = o_count + 1'b1;
      2'b01:   cnt_nxt = o_count - 1'b1;
      default: cnt_nxt = o_count;
    endcase
  end

  // Stage p0: RAM write and read issue; read data returns one cycle later
  bram_sdp #(
    .WIDTH_DATA (WIDTH_DATA),
    .WIDTH_ADDR (WIDTH_ADDR)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (push & ~i_flush),
    .i_waddr (wptr[WIDTH_ADDR-1:0]),
    .i_wdata (i_WDATA),
    .i_re    (issue & ~i_flush),
    .i_raddr (rptr[WIDTH_ADDR-1:0]),
    .o_rdata (ram_rdata_p0)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr           <= '0;
      rptr           <= '0;
      vld_p0         <= 1'b0;
      o_count        <= '0;
      o_wr_ready     <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else if (i_flush) begin
      wptr           <= '0;
      rptr           <= '0;
      vld_p0         <= 1'b0;
      o_count        <= '0;
      o_wr_ready     <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (issue) begin
        rptr <= rptr + 1'b1;
      end
      vld_p0         <= issue;
      o_count        <= cnt_nxt;
      o_wr_ready     <= (cnt_nxt != DEPTH_C);
      o_almost_full  <= (cnt_nxt >= AFULL_C);
      o_almost_empty <= (cnt_nxt <= AEMPTY_C);
    end
  end

  // Stage p1: head/spare output buffer; returning data bypasses to head when it frees up
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_vld_p1   <= 1'b0;
      spare_vld_p1  <= 1'b0;
      head_data_p1  <= '0;
      spare_data_p1 <= '0;
    end else if (i_flush) begin
      head_vld_p1   <= 1'b0;
      spare_vld_p1  <= 1'b0;
      head_data_p1  <= '0;
      spare_data_p1 <= '0;
    end else if (pop) begin
      if (spare_vld_p1) begin
        head_data_p1 <= spare_data_p1;
        if (vld_p0) begin
          spare_data_p1 <= ram_rdata_p0;
        end else begin
          spare_vld_p1 <= 1'b0;
        end
      end else if (vld_p0) begin
        head_data_p1 <= ram_rdata_p0;
      end else begin
        head_vld_p1 <= 1'b0;
      end
    end else if (vld_p0) begin
      if (!head_vld_p1) begin
        head_data_p1 <= ram_rdata_p0;
        head_vld_p1  <= 1'b1;
      end else begin
        spare_data_p1 <= ram_rdata_p0;
        spare_vld_p1  <= 1'b1;
      end
    end
  end

  assign o_rd_valid = head_vld_p1;
  assign o_RDATA    = head_data_p1;

endmodule
